// File: rtl/mac_vector_pkg.sv
// Shared types and helpers for the MAC vector engine: FSM state encoding
// and the per-mode saturation bounds used by every lane.
package mac_vector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bounds are returned at a fixed generous width; callers truncate to their
  // own working width, which is always wide enough to hold them exactly.
  localparam int BOUND_W = 64;

  // Largest representable accumulator value for the given width and mode.
  function automatic logic signed [BOUND_W-1:0] sat_hi(input int acc_w, input logic is_signed);
    return is_signed ? ((64'sd1 <<< (acc_w - 1)) - 64'sd1)
                     : ((64'sd1 <<< acc_w) - 64'sd1);
  endfunction

  // Smallest representable accumulator value for the given width and mode.
  function automatic logic signed [BOUND_W-1:0] sat_lo(input int acc_w, input logic is_signed);
    return is_signed ? -(64'sd1 <<< (acc_w - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One output lane: a single multiplier, a saturating accumulator and a
// sticky saturation flag. Operand signedness follows the latched job mode.
module mac_lane
  import mac_vector_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic                  signed_mode_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic [DATA_WIDTH-1:0] v_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic                  sat_o
);

  localparam int PROD_W = 2 * DATA_WIDTH + 1;
  // Two guard bits above the wider of accumulator and product so the sum of
  // the extended accumulator and product can never wrap before clamping.
  localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 2;

  logic [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic                      sat_q;
  logic signed [DATA_WIDTH:0] w_ext, v_ext;
  logic signed [PROD_W-1:0]  prod;
  logic signed [SUM_W-1:0]   acc_ext, prod_ext, sum, hi, lo;
  logic                      ovf_hi, ovf_lo;

  // Multiply, accumulate at full precision, then clamp into the mode's range.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here by
    // straight-line assignment) so no latch can be inferred.
    w_ext    = {signed_mode_i & w_i[DATA_WIDTH-1], w_i};
    v_ext    = {signed_mode_i & v_i[DATA_WIDTH-1], v_i};
    prod     = w_ext * v_ext;
    acc_ext  = {{(SUM_W - ACC_WIDTH){signed_mode_i & acc_q[ACC_WIDTH-1]}}, acc_q};
    prod_ext = {{(SUM_W - PROD_W){prod[PROD_W-1]}}, prod};
    sum      = acc_ext + prod_ext;
    hi       = SUM_W'(sat_hi(ACC_WIDTH, signed_mode_i));
    lo       = SUM_W'(sat_lo(ACC_WIDTH, signed_mode_i));
    ovf_hi   = sum > hi;
    ovf_lo   = sum < lo;
    if (ovf_hi)      acc_d = hi[ACC_WIDTH-1:0];
    else if (ovf_lo) acc_d = lo[ACC_WIDTH-1:0];
    else             acc_d = sum[ACC_WIDTH-1:0];
  end

  // Accumulator and sticky flag: cleared by reset or job start, updated per beat.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order. The accumulator
    // is explicitly reset because an aborted job must leave no residue.
    if (srst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (clear_i) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (en_i) begin
      acc_q <= acc_d;
      if (ovf_hi || ovf_lo) sat_q <= 1'b1;
    end
  end

  assign acc_o = acc_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/mac_vector_engine.sv
// Vector MAC engine: ARRAY_SIZE lanes each accumulate weight*vector over
// k_len beats, then present the lane results until the consumer takes them.
module mac_vector_engine
  import mac_vector_pkg::*;
#(
  parameter  int ARRAY_SIZE = 8,
  parameter  int DATA_WIDTH = 8,
  parameter  int ACC_WIDTH  = 32,
  parameter  int K_MAX      = 512,
  localparam int CNT_WIDTH  = $clog2(K_MAX + 1)
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             k_len,
  input  logic                             signed_mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_w,
  input  logic [DATA_WIDTH-1:0]            in_v,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data,
  output logic [ARRAY_SIZE-1:0]            out_sat,
  output logic                             busy
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] klen_q, klen_d;
  logic                 smode_q, smode_d;
  logic [CNT_WIDTH-1:0] k_eff;
  logic                 clear;
  logic                 beat;

  assign k_eff = (k_len > CNT_WIDTH'(K_MAX)) ? CNT_WIDTH'(K_MAX) : k_len;
  assign beat  = (state_q == ST_ACCUM) && in_valid;

  // Next-state logic: job acceptance, beat counting and result handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    smode_d = smode_q;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          cnt_d   = '0;
          klen_d  = k_eff;
          smode_d = signed_mode;
          state_d = (k_len == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == klen_q - 1'b1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset wins over every other event in the same cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      smode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      smode_q <= smode_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

  // Lane 0 sits in the MSBs of every packed bus.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk          (clk),
      .srst         (srst),
      .clear_i      (clear),
      .en_i         (beat),
      .signed_mode_i(smode_q),
      .w_i          (in_w[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH]),
      .v_i          (in_v),
      .acc_o        (out_data[(ARRAY_SIZE-1-i)*ACC_WIDTH +: ACC_WIDTH]),
      .sat_o        (out_sat[ARRAY_SIZE-1-i])
    );
  end

endmodule
